// File: rtl/apb_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_arb_pkg
//  Description : Shared constants for the APB master arbiter: default bus
//                geometry, ACCESS timeout, FSM state encodings and the
//                requester-index width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

   localparam int c_NREQ_DEF    = 4;
   localparam int c_AW_DEF      = 8;
   localparam int c_DW_DEF      = 8;
   localparam int c_TIMEOUT_DEF = 15;

   // FSM state encoding (plain constants so legacy code can share them)
   typedef logic [1:0] state_t;
   localparam state_t c_ST_IDLE   = 2'd0;
   localparam state_t c_ST_SETUP  = 2'd1;
   localparam state_t c_ST_ACCESS = 2'd2;

   // Width of a requester index; never narrower than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_arbiter_if
//  Description : APB bus bundle between the arbiter (master) and one slave.
//  Ports       : psel/penable/pwrite/paddr/pwdata driven by the master,
//                prdata/pready driven by the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_master_arbiter_if #(
   parameter int AW = apb_arb_pkg::c_AW_DEF,
   parameter int DW = apb_arb_pkg::c_DW_DEF
);
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata;
   logic          pready;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );
endinterface
`default_nettype wire

// File: rtl/apb_master_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. The winner is the first set
//                request bit found searching upward from ptr+1 with wrap.
//  Ports       : req  - request vector
//                ptr  - index of the previous winner
//                gnt  - one-hot grant, idx - its index, any - some request set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic [IDX_W-1:0] w_cand;

   // Walk from the farthest candidate to the nearest so the nearest set
   // request (smallest distance past ptr) is the last one written.
   always_comb begin
      gnt    = '0;
      idx    = '0;
      w_cand = '0;
      any    = |req;
      for (int k = NREQ; k >= 1; k--) begin
         w_cand = IDX_W'((int'(ptr) + k) % NREQ);
         if (req[w_cand]) begin
            gnt         = '0;
            gnt[w_cand] = 1'b1;
            idx         = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_arbiter
//  Description : Shares one APB bus between NREQ requesters. Round-robin
//                grant, one transfer in flight, SETUP/ACCESS sequencing,
//                per-requester response pulse and ACCESS-phase timeout.
//  Ports       : pclk, preset            - clock, async active-high reset
//                req_valid/write/addr/wdata - packed requester inputs
//                req_ready               - one-cycle accept pulse
//                rsp_valid/rdata/err     - one-cycle completion pulse + data
//                apb                     - APB master modport
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NREQ    = c_NREQ_DEF,
   parameter int AW      = c_AW_DEF,
   parameter int DW      = c_DW_DEF,
   parameter int TIMEOUT = c_TIMEOUT_DEF
) (
   input  logic                 pclk,
   input  logic                 preset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_write,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [DW-1:0]        rsp_rdata,
   output logic                 rsp_err,
   apb_master_arbiter_if.master apb
);

   localparam int IDX_W = idx_w(NREQ);
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
   // Pointer starts at the last requester so requester 0 wins first
   localparam logic [IDX_W-1:0] c_PTR_RST  = IDX_W'(NREQ - 1);

   state_t           r_state;
   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic             r_psel;
   logic             r_penable;
   logic             r_pwrite;
   logic [AW-1:0]    r_paddr;
   logic [DW-1:0]    r_pwdata;
   logic [NREQ-1:0]  r_req_ready;
   logic [NREQ-1:0]  r_rsp_valid;
   logic [DW-1:0]    r_rsp_rdata;
   logic             r_rsp_err;

   logic [NREQ-1:0]  w_gnt;
   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic [AW-1:0]    w_addr  [NREQ];
   logic [DW-1:0]    w_wdata [NREQ];

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign w_addr[i]  = req_addr[i*AW +: AW];
      assign w_wdata[i] = req_wdata[i*DW +: DW];
   end

   rr_arbiter #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req (req_valid),
      .ptr (r_ptr),
      .gnt (w_gnt),
      .idx (w_idx),
      .any (w_any)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_state     <= c_ST_IDLE;
         r_ptr       <= c_PTR_RST;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         // Both handshake outputs are single-cycle pulses
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_any) begin
                  r_paddr     <= w_addr[w_idx];
                  r_pwdata    <= w_wdata[w_idx];
                  r_pwrite    <= req_write[w_idx];
                  r_idx       <= w_idx;
                  r_ptr       <= w_idx;
                  r_psel      <= 1'b1;
                  r_penable   <= 1'b0;
                  r_req_ready <= w_gnt;
                  r_state     <= c_ST_SETUP;
               end else begin
                  r_psel <= 1'b0;
               end
            end
            c_ST_SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= c_ST_ACCESS;
            end
            c_ST_ACCESS: begin
               // pready wins over the timeout in the last allowed cycle
               if (apb.pready) begin
                  r_psel             <= 1'b0;
                  r_penable          <= 1'b0;
                  r_rsp_valid[r_idx] <= 1'b1;
                  r_rsp_err          <= 1'b0;
                  r_rsp_rdata        <= r_pwrite ? '0 : apb.prdata;
                  r_state            <= c_ST_IDLE;
               end else if (r_cnt == c_CNT_LAST) begin
                  r_psel             <= 1'b0;
                  r_penable          <= 1'b0;
                  r_rsp_valid[r_idx] <= 1'b1;
                  r_rsp_err          <= 1'b1;
                  r_rsp_rdata        <= '0;
                  r_state            <= c_ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign apb.psel    = r_psel;
   assign apb.penable = r_penable;
   assign apb.pwrite  = r_pwrite;
   assign apb.paddr   = r_paddr;
   assign apb.pwdata  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_arbiter
//  Description : Self-checking bench for apb_master_arbiter with an APB slave
//                memory model whose pready delay is programmable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

   typedef struct {
      int         idx;
      logic [7:0] rdata;
      logic       err;
   } rsp_t;

   logic       pclk;
   logic       preset;
   logic [3:0] req_valid;
   logic [3:0] req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0] req_ready;
   logic [3:0] rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;

   apb_master_arbiter_if #(.AW(8), .DW(8)) apb ();

   apb_master_arbiter #(
      .NREQ (4), .AW (8), .DW (8), .TIMEOUT (15)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .apb       (apb)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // ---------------- slave model ----------------
   logic [7:0] slv_mem [256];
   logic [7:0] ref_mem [256];
   int         ready_delay;
   int         acc_cnt;

   assign apb.pready = apb.psel && apb.penable && (acc_cnt >= ready_delay);
   assign apb.prdata = slv_mem[apb.paddr];

   always @(posedge pclk or posedge preset) begin
      if (preset) acc_cnt <= 0;
      else if (apb.psel && apb.penable) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   always @(posedge pclk) begin
      if (!preset && apb.psel && apb.penable && apb.pready && apb.pwrite)
         slv_mem[apb.paddr] <= apb.pwdata;
   end

   // ---------------- monitors ----------------
   rsp_t exp_q [$];
   rsp_t obs_q [$];
   int   grant_q [$];
   int   b2b_viol, phase_viol, run_len, last_len;
   logic prev_psel, prev_pen, prev_wr;
   logic [7:0] prev_addr, prev_wd;
   int   n_cmp, n_bad;

   initial begin
      b2b_viol = 0; phase_viol = 0; run_len = 0; last_len = 0;
      prev_psel = 1'b0; prev_pen = 1'b0; prev_wr = 1'b0;
      prev_addr = '0; prev_wd = '0;
   end

   always @(negedge pclk) begin
      rsp_t o;
      for (int k = 0; k < 4; k++)
         if (req_ready[k]) grant_q.push_back(k);
      if (|rsp_valid) begin
         o.idx = -1;
         for (int k = 3; k >= 0; k--)
            if (rsp_valid[k]) o.idx = k;
         if ($countones(rsp_valid) != 1) o.idx = -1;
         o.rdata = rsp_rdata;
         o.err   = rsp_err;
         obs_q.push_back(o);
      end
      if (apb.psel && !apb.penable && prev_psel) b2b_viol++;
      if (prev_psel && !prev_pen && !preset && !(apb.psel && apb.penable)) phase_viol++;
      if (prev_psel && apb.psel &&
          (apb.paddr !== prev_addr || apb.pwrite !== prev_wr || apb.pwdata !== prev_wd))
         phase_viol++;
      if (apb.psel && apb.penable) run_len++;
      else if (run_len != 0) begin
         last_len = run_len;
         run_len  = 0;
      end
      prev_psel = apb.psel;
      prev_pen  = apb.penable;
      prev_addr = apb.paddr;
      prev_wr   = apb.pwrite;
      prev_wd   = apb.pwdata;
   end

   // ---------------- helpers (stimulus / bounded waits) ----------------
   task automatic tick();
      @(negedge pclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
      req_valid[i]       = 1'b1;
      req_write[i]       = w;
      req_addr[i*8 +: 8]  = a;
      req_wdata[i*8 +: 8] = d;
   endtask

   task automatic push_exp(input int i, input logic [7:0] rd, input logic e);
      rsp_t x;
      x.idx = i; x.rdata = rd; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic wait_ready(input int i);
      int b;
      b = 0;
      do begin
         tick();
         b++;
      end while (!req_ready[i] && b < 100);
      if (!req_ready[i]) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_ready%0d: no req_ready after %0d cycles", i, b);
      end
   endtask

   task automatic wait_obs(input int n);
      int b;
      b = 0;
      while (obs_q.size() < n && b < 100) begin
         tick();
         b++;
      end
      if (obs_q.size() < n) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_rsp: got %0d responses, need %0d", obs_q.size(), n);
      end
   endtask

   task automatic do_reset();
      preset    = 1'b1;
      req_valid = '0;
      tick();
      tick();
      preset = 1'b0;
      exp_q.delete(); obs_q.delete(); grant_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      preset = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin
         n_bad++; $display("FAIL reset_psel: psel=%b penable=%b, need 0/0", apb.psel, apb.penable);
      end
      n_cmp++;
      if (apb.paddr !== 8'h00 || apb.pwdata !== 8'h00 || apb.pwrite !== 1'b0) begin
         n_bad++; $display("FAIL reset_bus: paddr=%h pwdata=%h pwrite=%b, need 00/00/0",
                           apb.paddr, apb.pwdata, apb.pwrite);
      end
      n_cmp++;
      if (req_ready !== 4'h0 || rsp_valid !== 4'h0) begin
         n_bad++; $display("FAIL reset_hs: req_ready=%b rsp_valid=%b, need 0000/0000", req_ready, rsp_valid);
      end
      n_cmp++;
      if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_rsp: rdata=%h err=%b, need 00/0", rsp_rdata, rsp_err);
      end
      preset = 1'b0;
   endtask

   task automatic test_write();
      rsp_t o, e;
      ready_delay = 0;
      set_req(0, 1'b1, 8'h05, 8'hA5);
      push_exp(0, 8'h00, 1'b0);
      ref_mem[8'h05] = 8'hA5;
      tick();
      n_cmp++;
      if (req_ready !== 4'b0001 || apb.psel !== 1'b1 || apb.penable !== 1'b0) begin
         n_bad++; $display("FAIL wr_setup: req_ready=%b psel=%b penable=%b, need 0001/1/0",
                           req_ready, apb.psel, apb.penable);
      end
      n_cmp++;
      if (apb.paddr !== 8'h05 || apb.pwdata !== 8'hA5 || apb.pwrite !== 1'b1) begin
         n_bad++; $display("FAIL wr_fields: paddr=%h pwdata=%h pwrite=%b, need 05/a5/1",
                           apb.paddr, apb.pwdata, apb.pwrite);
      end
      req_valid[0] = 1'b0;
      tick();
      n_cmp++;
      if (apb.psel !== 1'b1 || apb.penable !== 1'b1 || req_ready !== 4'b0000) begin
         n_bad++; $display("FAIL wr_access: psel=%b penable=%b req_ready=%b, need 1/1/0000",
                           apb.psel, apb.penable, req_ready);
      end
      tick();
      n_cmp++;
      if (rsp_valid !== 4'b0001 || apb.psel !== 1'b0 || apb.penable !== 1'b0) begin
         n_bad++; $display("FAIL wr_done: rsp_valid=%b psel=%b penable=%b, need 0001/0/0",
                           rsp_valid, apb.psel, apb.penable);
      end
      wait_obs(1);
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL wr_rsp: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_read();
      rsp_t o, e;
      ready_delay = 0;
      set_req(1, 1'b0, 8'h05, 8'h00);
      push_exp(1, ref_mem[8'h05], 1'b0);
      wait_ready(1);
      n_cmp++;
      if (apb.psel !== 1'b1 || apb.pwrite !== 1'b0 || apb.paddr !== 8'h05) begin
         n_bad++; $display("FAIL rd_setup: psel=%b pwrite=%b paddr=%h, need 1/0/05",
                           apb.psel, apb.pwrite, apb.paddr);
      end
      req_valid[1] = 1'b0;
      tick();
      n_cmp++;
      if (apb.penable !== 1'b1 || apb.pwrite !== 1'b0) begin
         n_bad++; $display("FAIL rd_access: penable=%b pwrite=%b, need 1/0", apb.penable, apb.pwrite);
      end
      wait_obs(1);
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL rd_rsp: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_round_robin();
      rsp_t o, e;
      int   order [5];
      int   b;
      order = '{0, 1, 2, 3, 0};
      do_reset();
      b2b_viol = 0; phase_viol = 0;
      ready_delay = 0;
      for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h10 + 8'(i), 8'h00);
      for (int k = 0; k < 5; k++) push_exp(order[k], ref_mem[8'h10 + 8'(order[k])], 1'b0);
      b = 0;
      while (grant_q.size() < 5 && b < 200) begin
         tick();
         b++;
      end
      req_valid = '0;
      wait_obs(5);
      for (int k = 0; k < 5; k++) begin
         n_cmp++;
         if (k >= grant_q.size() || grant_q[k] !== order[k]) begin
            n_bad++; $display("FAIL rr_grant%0d: got %0d, need %0d", k,
                              (k < grant_q.size()) ? grant_q[k] : -1, order[k]);
         end
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL rr_rsp: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
      n_cmp++;
      if (b2b_viol !== 0 || phase_viol !== 0) begin
         n_bad++; $display("FAIL rr_phases: b2b=%0d phase=%0d, need 0/0", b2b_viol, phase_viol);
      end
   endtask

   task automatic test_timeout();
      rsp_t o, e;
      ready_delay = 255;
      set_req(2, 1'b1, 8'h20, 8'h77);
      push_exp(2, 8'h00, 1'b1);
      wait_ready(2);
      req_valid[2] = 1'b0;
      wait_obs(1);
      n_cmp++;
      if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || last_len !== 15) begin
         n_bad++; $display("FAIL to_abort: psel=%b penable=%b access_cycles=%0d, need 0/0/15",
                           apb.psel, apb.penable, last_len);
      end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL to_rsp: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
      // Aborted write must not have landed; next transfer proceeds normally
      ready_delay = 0;
      set_req(2, 1'b0, 8'h20, 8'h00);
      push_exp(2, ref_mem[8'h20], 1'b0);
      wait_ready(2);
      req_valid[2] = 1'b0;
      wait_obs(1);
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL to_next: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_last_cycle_ready();
      rsp_t o, e;
      ready_delay = 14;
      set_req(3, 1'b1, 8'h30, 8'h5A);
      push_exp(3, 8'h00, 1'b0);
      ref_mem[8'h30] = 8'h5A;
      wait_ready(3);
      req_valid[3] = 1'b0;
      wait_obs(1);
      n_cmp++;
      if (last_len !== 15) begin
         n_bad++; $display("FAIL last_len: access_cycles=%0d, need 15", last_len);
      end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL last_rsp: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
      ready_delay = 0;
      set_req(0, 1'b0, 8'h30, 8'h00);
      push_exp(0, ref_mem[8'h30], 1'b0);
      wait_ready(0);
      req_valid[0] = 1'b0;
      wait_obs(1);
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL last_readback: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_reset_mid_transfer();
      rsp_t o, e;
      int   b;
      ready_delay = 255;
      set_req(1, 1'b0, 8'h44, 8'h00);
      wait_ready(1);
      req_valid[1] = 1'b0;
      tick(); tick(); tick();
      preset = 1'b1;
      #1;
      n_cmp++;
      if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || apb.paddr !== 8'h00 ||
          apb.pwdata !== 8'h00 || apb.pwrite !== 1'b0) begin
         n_bad++; $display("FAIL async_bus: psel=%b penable=%b paddr=%h pwdata=%h pwrite=%b, need all 0",
                           apb.psel, apb.penable, apb.paddr, apb.pwdata, apb.pwrite);
      end
      n_cmp++;
      if (req_ready !== 4'h0 || rsp_valid !== 4'h0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
         n_bad++; $display("FAIL async_rsp: req_ready=%b rsp_valid=%b rdata=%h err=%b, need all 0",
                           req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      exp_q.delete(); grant_q.delete();
      set_req(3, 1'b0, 8'h30, 8'h00);
      set_req(0, 1'b1, 8'h50, 8'h11);
      tick(); tick();
      preset = 1'b0;
      ready_delay = 0;
      push_exp(0, 8'h00, 1'b0);
      push_exp(3, ref_mem[8'h30], 1'b0);
      ref_mem[8'h50] = 8'h11;
      b = 0;
      while (grant_q.size() < 2 && b < 100) begin
         tick();
         if (req_ready[0]) req_valid[0] = 1'b0;
         if (req_ready[3]) req_valid[3] = 1'b0;
         b++;
      end
      req_valid = '0;
      n_cmp++;
      if (grant_q.size() < 2 || grant_q[0] !== 0 || grant_q[1] !== 3) begin
         n_bad++; $display("FAIL post_rst_order: got %0d grants first=%0d, need 0 then 3",
                           grant_q.size(), (grant_q.size() > 0) ? grant_q[0] : -1);
      end
      wait_obs(2);
      n_cmp++;
      if (obs_q.size() !== 2) begin
         n_bad++; $display("FAIL post_rst_count: got %0d responses, need 2 (dropped one absent)", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         n_cmp++;
         if (o.idx !== e.idx || o.rdata !== e.rdata || o.err !== e.err) begin
            n_bad++; $display("FAIL post_rst_rsp: got idx=%0d rdata=%h err=%b, need idx=%0d rdata=%h err=%b",
                              o.idx, o.rdata, o.err, e.idx, e.rdata, e.err);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      preset = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      ready_delay = 0;
      for (int a = 0; a < 256; a++) begin
         slv_mem[a] = 8'(a) ^ 8'h3C;
         ref_mem[a] = 8'(a) ^ 8'h3C;
      end
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_timeout();
      test_last_cycle_ready();
      test_reset_mid_transfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
